// File: rtl/multi_edge_detector_if.sv
// Signal bundle for multi_edge_detector: raw inputs, per-channel controls and
// the pulse/status outputs. The block consumes it through the slave modport.
interface multi_edge_detector_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0]       a_i;
  logic [2*WIDTH-1:0]     mode_i;
  logic [WIDTH-1:0]       clr_i;
  logic [WIDTH-1:0]       rising_edge_o;
  logic [WIDTH-1:0]       falling_edge_o;
  logic [WIDTH-1:0]       event_o;
  logic [WIDTH-1:0]       sticky_o;
  logic [WIDTH*CNT_W-1:0] cnt_o;
  logic                   irq_o;

  modport master (
    output a_i, mode_i, clr_i,
    input  rising_edge_o, falling_edge_o, event_o, sticky_o, cnt_o, irq_o
  );

  modport slave (
    input  a_i, mode_i, clr_i,
    output rising_edge_o, falling_edge_o, event_o, sticky_o, cnt_o, irq_o
  );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel synchronised, debounced edge detector with per-channel
// mode-qualified events, sticky flags, saturating counters and a shared irq.

module multi_edge_detector_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 2,
  parameter int CNT_W       = 4,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             rise,
  output logic             fall,
  output logic             evt,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);
  localparam int               DC_W    = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [DC_W-1:0]  DC_MAX  = DC_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   f_q;
  logic [DC_W-1:0]        dc_q;
  logic                   s;
  logic                   commit;

  assign s      = sync_q[SYNC_STAGES-1];
  assign commit = (s != f_q) && (dc_q == DC_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q[0] <= a;
      for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
    end
  end

  // Any return to the accepted level restarts the persistence count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_q  <= RESET_VAL;
      dc_q <= '0;
    end else if (s == f_q) begin
      dc_q <= '0;
    end else if (dc_q == DC_MAX) begin
      f_q  <= s;
      dc_q <= '0;
    end else begin
      dc_q <= dc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
      evt  <= 1'b0;
    end else begin
      rise <= commit & s;
      fall <= commit & ~s;
      evt  <= commit & ((s & mode[0]) | (~s & mode[1]));
    end
  end

  // Sticky/counter follow the registered event pulse; a set beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else begin
      if (evt)      sticky <= 1'b1;
      else if (clr) sticky <= 1'b0;

      if (clr)                         cnt <= CNT_W'(evt);
      else if (evt && cnt != CNT_MAX)  cnt <= cnt + 1'b1;
    end
  end
endmodule

module multi_edge_detector #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 2,
  parameter int CNT_W       = 4,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_edge_detector_if.slave bus
);
  logic [WIDTH-1:0][1:0]       mode;
  logic [WIDTH-1:0]            rise;
  logic [WIDTH-1:0]            fall;
  logic [WIDTH-1:0]            evt;
  logic [WIDTH-1:0]            sticky;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  logic                        irq_q;

  assign mode = bus.mode_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    multi_edge_detector_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE),
      .CNT_W       (CNT_W),
      .RESET_VAL   (RESET_VAL)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .a      (bus.a_i[i]),
      .mode   (mode[i]),
      .clr    (bus.clr_i[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .evt    (evt[i]),
      .sticky (sticky[i]),
      .cnt    (cnt[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= |sticky;
  end

  assign bus.rising_edge_o  = rise;
  assign bus.falling_edge_o = fall;
  assign bus.event_o        = evt;
  assign bus.sticky_o       = sticky;
  assign bus.cnt_o          = cnt;
  assign bus.irq_o          = irq_q;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed vectors on the default build plus a
// history-based reference model checking three builds every cycle.
module tb_multi_edge_detector;
  localparam int W    = 4;
  localparam int CW   = 4;
  localparam int HMAX = 1024;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   clr = '0;
  logic [2*W-1:0] mode = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_edge_detector_if #(.WIDTH(W), .CNT_W(CW)) if0 ();
  multi_edge_detector_if #(.WIDTH(W), .CNT_W(CW)) if1 ();
  multi_edge_detector_if #(.WIDTH(W), .CNT_W(CW)) if2 ();

  assign if0.a_i = a;  assign if0.mode_i = mode;  assign if0.clr_i = clr;
  assign if1.a_i = a;  assign if1.mode_i = mode;  assign if1.clr_i = clr;
  assign if2.a_i = a;  assign if2.mode_i = mode;  assign if2.clr_i = clr;

  multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE(2), .CNT_W(CW), .RESET_VAL(1'b0))
    dut0 (.clk(clk), .reset(rst_n), .bus(if0));
  multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(1), .DEBOUNCE(0), .CNT_W(CW), .RESET_VAL(1'b0))
    dut1 (.clk(clk), .reset(rst_n), .bus(if1));
  multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE(2), .CNT_W(CW), .RESET_VAL(1'b1))
    dut2 (.clk(clk), .reset(rst_n), .bus(if2));

  logic [W-1:0]    o_rise [3];
  logic [W-1:0]    o_fall [3];
  logic [W-1:0]    o_evt  [3];
  logic [W-1:0]    o_stk  [3];
  logic [W*CW-1:0] o_cnt  [3];
  logic            o_irq  [3];

  assign o_rise[0] = if0.rising_edge_o;  assign o_fall[0] = if0.falling_edge_o;
  assign o_evt[0]  = if0.event_o;        assign o_stk[0]  = if0.sticky_o;
  assign o_cnt[0]  = if0.cnt_o;          assign o_irq[0]  = if0.irq_o;
  assign o_rise[1] = if1.rising_edge_o;  assign o_fall[1] = if1.falling_edge_o;
  assign o_evt[1]  = if1.event_o;        assign o_stk[1]  = if1.sticky_o;
  assign o_cnt[1]  = if1.cnt_o;          assign o_irq[1]  = if1.irq_o;
  assign o_rise[2] = if2.rising_edge_o;  assign o_fall[2] = if2.falling_edge_o;
  assign o_evt[2]  = if2.event_o;        assign o_stk[2]  = if2.sticky_o;
  assign o_cnt[2]  = if2.cnt_o;          assign o_irq[2]  = if2.irq_o;

  // ---------------- reference model ----------------
  // Keeps the raw input history since reset; a level is accepted at edge t
  // when the synchronised view differs from the accepted level over the whole
  // window of DEBOUNCE+1 edges ending at t.
  bit         ah   [3][W][HMAX];
  int         n    [3];
  bit         mf   [3][W];
  bit [W-1:0] er   [3];
  bit [W-1:0] ef   [3];
  bit [W-1:0] ee   [3];
  bit [W-1:0] es   [3];
  int         ecnt [3][W];
  bit         eirq [3];

  function automatic int sp(int d); return (d == 1) ? 1 : 2; endfunction
  function automatic int dp(int d); return (d == 1) ? 0 : 2; endfunction
  function automatic bit rv(int d); return (d == 2); endfunction

  function automatic bit s_at(int d, int c, int t);
    int idx;
    idx = t - sp(d);
    if (idx < 0) return rv(d);
    return ah[d][c][idx];
  endfunction

  function automatic logic [W*CW-1:0] ecnt_vec(int d);
    logic [W*CW-1:0] v;
    v = '0;
    for (int c = 0; c < W; c++) v[c*CW +: CW] = CW'(ecnt[d][c]);
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      n[d] = 0; er[d] = '0; ef[d] = '0; ee[d] = '0; es[d] = '0; eirq[d] = 1'b0;
      for (int c = 0; c < W; c++) begin
        mf[d][c] = rv(d);
        ecnt[d][c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      int t;
      bit ok;
      bit [W-1:0] nr, nf, ne, ns;
      bit ni;
      t = n[d];
      if (t >= HMAX) begin
        errors++;
        $display("FAIL model_history dut%0d: edge %0d beyond %0d", d, t, HMAX);
        continue;
      end
      ni = |es[d];
      nr = '0; nf = '0; ne = '0; ns = es[d];
      for (int c = 0; c < W; c++) begin
        ah[d][c][t] = a[c];
        ok = (t - dp(d) >= 0);
        for (int j = t - dp(d); j <= t; j++)
          if (j >= 0 && s_at(d, c, j) == mf[d][c]) ok = 1'b0;
        if (ok) begin
          mf[d][c] = !mf[d][c];
          nr[c] = mf[d][c];
          nf[c] = !mf[d][c];
        end
        ne[c] = (nr[c] & mode[2*c]) | (nf[c] & mode[2*c+1]);
        if (clr[c])                            ecnt[d][c] = ee[d][c] ? 1 : 0;
        else if (ee[d][c] && ecnt[d][c] < MAXC) ecnt[d][c] = ecnt[d][c] + 1;
        if (ee[d][c])    ns[c] = 1'b1;
        else if (clr[c]) ns[c] = 1'b0;
      end
      es[d] = ns; eirq[d] = ni; er[d] = nr; ef[d] = nf; ee[d] = ne;
      n[d] = t + 1;
    end
  endtask

  task automatic compare_dut(int d);
    checks++;
    if ({o_rise[d], o_fall[d], o_evt[d], o_stk[d], o_cnt[d], o_irq[d]} !==
        {er[d], ef[d], ee[d], es[d], ecnt_vec(d), eirq[d]}) begin
      errors++;
      $display("FAIL model dut%0d @%0t: got r%h f%h e%h s%h c%h i%b, expected r%h f%h e%h s%h c%h i%b",
               d, $time, o_rise[d], o_fall[d], o_evt[d], o_stk[d], o_cnt[d], o_irq[d],
               er[d], ef[d], ee[d], es[d], ecnt_vec(d), eirq[d]);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    for (int d = 0; d < 3; d++) compare_dut(d);
  end

  // ---------------- directed helpers ----------------
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [63:0] allout(int d);
    return 64'({o_rise[d], o_fall[d], o_evt[d], o_stk[d], o_cnt[d], o_irq[d]});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       a0;
    logic       clr0;
    logic       rise, fall, evt, stk, irq;
    logic [3:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic a0, logic c0, logic r, logic f, logic e,
                              logic s, logic i, logic [3:0] cn);
    vec_t v;
    v.a0 = a0; v.clr0 = c0; v.rise = r; v.fall = f; v.evt = e;
    v.stk = s; v.irq = i; v.cnt = cn;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int evcnt;

    // reset quiet: RESET_VAL=0 builds with all-zero input
    mode = 8'hFF;
    a    = 4'h0;
    do_reset();
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      chk("quiet_rv0_dut0", allout(0), 64'h0);
      chk("quiet_rv0_dut1", allout(1), 64'h0);
    end

    // reset quiet: RESET_VAL=1 build with all-one input
    a = 4'hF;
    do_reset();
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      chk("quiet_rv1_dut2", allout(2), 64'h0);
    end

    // ch0 rise/fall table on the default build
    a    = 4'h0;
    mode = {2'b01, 2'b11, 2'b11, 2'b01};
    do_reset();
    repeat (8) @(negedge clk);
    for (int i = 0; i < 17; i++) tbl[i] = mk(1'b0, 1'b0, 0, 0, 0, 1, 1, 4'd1);
    for (int i = 0; i < 5; i++)  tbl[i] = mk(1'b1, 1'b0, 0, 0, 0, 0, 0, 4'd0);
    tbl[5]  = mk(1'b1, 1'b0, 1, 0, 1, 0, 0, 4'd0);
    tbl[6]  = mk(1'b1, 1'b0, 0, 0, 0, 1, 0, 4'd1);
    tbl[12] = mk(1'b0, 1'b0, 0, 1, 0, 1, 1, 4'd1);
    tbl[14] = mk(1'b0, 1'b1, 0, 0, 0, 1, 1, 4'd1);
    tbl[15] = mk(1'b0, 1'b0, 0, 0, 0, 0, 1, 4'd0);
    tbl[16] = mk(1'b0, 1'b0, 0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk($sformatf("tbl_ch0_step%0d", i),
          64'({o_rise[0][0], o_fall[0][0], o_evt[0][0], o_stk[0][0], o_irq[0], o_cnt[0][3:0]}),
          64'({tbl[i].rise, tbl[i].fall, tbl[i].evt, tbl[i].stk, tbl[i].irq, tbl[i].cnt}));
      a[0]   = tbl[i].a0;
      clr[0] = tbl[i].clr0;
    end
    clr = '0;

    // ch1: 2-cycle glitch is dropped
    for (int m = 0; m < 15; m++) begin
      @(negedge clk);
      chk("glitch_ch1", 64'({o_rise[0][1], o_fall[0][1]}), 64'h0);
      a[1] = (m < 2);
    end
    // ch1: 3-cycle pulse gives one rise and one fall
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      chk($sformatf("pulse_ch1_step%0d", m), 64'({o_rise[0][1], o_fall[0][1]}),
          64'({(m == 5), (m == 8)}));
      a[1] = (m < 3);
    end

    @(negedge clk); clr = 4'hF;
    @(negedge clk); clr = 4'h0;

    // ch2: 20 toggles in both-edge mode, counter saturates
    evcnt = 0;
    for (int m = 0; m < 130; m++) begin
      @(negedge clk);
      if (o_evt[0][2]) evcnt++;
      a[2] = (m < 120) ? ((m / 6) % 2 == 0) : 1'b0;
    end
    chk("sat_ch2_events", 64'(evcnt), 64'd20);
    chk("sat_ch2_cnt", 64'(o_cnt[0][11:8]), 64'd15);
    chk("sat_ch2_sticky", 64'(o_stk[0][2]), 64'd1);
    chk("sat_irq_set", 64'(o_irq[0]), 64'd1);
    clr = 4'b0100;
    @(negedge clk);
    clr = 4'b0000;
    chk("clr_ch2_cnt_sticky", 64'({o_stk[0][2], o_cnt[0][11:8]}), 64'h0);
    @(negedge clk);
    chk("clr_ch2_irq", 64'(o_irq[0]), 64'd0);

    // ch3: clear coincident with event -> set wins, counter = 1
    for (int m = 0; m < 9; m++) begin
      @(negedge clk);
      if (m == 5) chk("ch3_event", 64'(o_evt[0][3]), 64'd1);
      if (m >= 6) chk($sformatf("ch3_setwins_step%0d", m),
                      64'({o_stk[0][3], o_cnt[0][15:12]}), 64'h11);
      a[3]   = 1'b1;
      clr[3] = (m == 5);
    end
    clr = '0;

    // async reset mid-debounce on ch0, between clock edges
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      a[0] = 1'b1;
    end
    @(negedge clk);
    chk("pre_reset_irq", 64'(o_irq[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_dut0", allout(0), 64'h0);
    chk("async_reset_dut2", allout(2), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int m = 1; m < 8; m++) begin
      @(negedge clk);
      chk($sformatf("post_reset_rise_ch0_step%0d", m), 64'(o_rise[0][0]), 64'(m == 5));
    end

    // random traffic, checked by the model on all builds
    for (int m = 0; m < 200; m++) begin
      @(negedge clk);
      if (m % 16 == 0) mode = 8'($urandom);
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(3) == 0) a[c] = ~a[c];
        clr[c] = ($urandom_range(7) == 0);
      end
    end
    clr = '0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
